// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, latency counter width and
// grant-owner encoding.
package mem_arb_pkg;

    localparam int unsigned LAT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyDm,
        StAck
    } arb_state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnDm = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating grant/conflict counters for mem_arbiter; only instantiated when
// ARB_PERF_CNT_EN is defined.
module mem_arb_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             if_grant_i,
    input  logic             dm_grant_i,
    input  logic             conflict_i,
    output logic [CNT_W-1:0] if_grant_cnt_o,
    output logic [CNT_W-1:0] dm_grant_cnt_o,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    logic [CNT_W-1:0] if_cnt_q, if_cnt_d;
    logic [CNT_W-1:0] dm_cnt_q, dm_cnt_d;
    logic [CNT_W-1:0] cf_cnt_q, cf_cnt_d;

    // Each counter sticks at all-ones rather than wrapping.
    always_comb begin
        if_cnt_d = if_cnt_q;
        dm_cnt_d = dm_cnt_q;
        cf_cnt_d = cf_cnt_q;
        if (if_grant_i && (if_cnt_q != '1)) if_cnt_d = if_cnt_q + 1'b1;
        if (dm_grant_i && (dm_cnt_q != '1)) dm_cnt_d = dm_cnt_q + 1'b1;
        if (conflict_i && (cf_cnt_q != '1)) cf_cnt_d = cf_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            if_cnt_q <= '0;
            dm_cnt_q <= '0;
            cf_cnt_q <= '0;
        end else begin
            if_cnt_q <= if_cnt_d;
            dm_cnt_q <= dm_cnt_d;
            cf_cnt_q <= cf_cnt_d;
        end
    end

    assign if_grant_cnt_o = if_cnt_q;
    assign dm_grant_cnt_o = dm_cnt_q;
    assign conflict_cnt_o = cf_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Data-first arbiter sharing one single-ported memory between fetch and data ports.
// Define ARB_PERF_CNT_EN to add saturating grant/conflict counter outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef ARB_PERF_CNT_EN
    output logic [ADDR_W-1:0] if_grant_cnt_o,
    output logic [ADDR_W-1:0] dm_grant_cnt_o,
    output logic [ADDR_W-1:0] conflict_cnt_o,
`endif
    output logic              stall_o
);

    arb_state_e        state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              if_elig, dm_elig;
    owner_e            owner;

    assign if_elig = if_req_i & ~if_ack_q;
    assign dm_elig = dm_req_i & ~dm_ack_q;
    assign owner   = (state_q == StBusyDm) ? OwnDm : OwnIf;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (dm_elig) begin
                    state_d     = StBusyDm;
                    cnt_d       = LAT_W'(MEM_LAT - 1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end else if (if_elig) begin
                    state_d     = StBusyIf;
                    cnt_d       = LAT_W'(MEM_LAT - 1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = dm_wdata_i;
                end
            end
            StBusyIf, StBusyDm: begin
                if (cnt_q == '0) begin
                    state_d  = StAck;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner == OwnDm) begin
                        dm_ack_d = 1'b1;
                        // Writes complete like reads but leave read data untouched.
                        if (!mem_we_q) dm_rdata_d = mem_rdata_i;
                    end else begin
                        if_ack_d  = 1'b1;
                        if_data_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign stall_o     = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

`ifdef ARB_PERF_CNT_EN
    logic idle_q;
    assign idle_q = (state_q == StIdle);

    mem_arb_perf_cnt #(
        .CNT_W(ADDR_W)
    ) u_perf_cnt (
        .clk_i         (clk_i),
        .start_i       (start_i),
        .if_grant_i    (idle_q & if_elig & ~dm_elig),
        .dm_grant_i    (idle_q & dm_elig),
        .conflict_i    (idle_q & dm_elig & if_elig),
        .if_grant_cnt_o(if_grant_cnt_o),
        .dm_grant_cnt_o(dm_grant_cnt_o),
        .conflict_cnt_o(conflict_cnt_o)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LAT=3); counter checks are included
// when ARB_PERF_CNT_EN is defined.
module tb_mem_arbiter;

    localparam int unsigned L = 3;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_grant_cnt_o;
    logic [31:0] dm_grant_cnt_o;
    logic [31:0] conflict_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .MEM_LAT(L)
    ) dut (
        .clk_i         (clk_i),
        .start_i       (start_i),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_data_o     (if_data_o),
        .if_ack_o      (if_ack_o),
        .dm_req_i      (dm_req_i),
        .dm_we_i       (dm_we_i),
        .dm_addr_i     (dm_addr_i),
        .dm_wdata_i    (dm_wdata_i),
        .dm_rdata_o    (dm_rdata_o),
        .dm_ack_o      (dm_ack_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
`ifdef ARB_PERF_CNT_EN
        .if_grant_cnt_o(if_grant_cnt_o),
        .dm_grant_cnt_o(dm_grant_cnt_o),
        .conflict_cnt_o(conflict_cnt_o),
`endif
        .stall_o       (stall_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ack(input bit is_dm, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (is_dm ? dm_ack_o : if_ack_o) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        start_i     = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        dm_addr_i   = '0;
        dm_wdata_i  = '0;
        mem_rdata_i = '0;

        // Reset state; stall stays combinational while in reset.
        #2 start_i = 1'b0;
        if_req_i = 1'b1;
        tick();
        tick();
        chk("rst_en", {31'd0, mem_en_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_if_ack", {31'd0, if_ack_o}, 32'd0);
        chk("rst_dm_ack", {31'd0, dm_ack_o}, 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_dm_rdata", dm_rdata_o, 32'd0);
        chk("rst_stall_hi", {31'd0, stall_o}, 32'd1);
        if_req_i = 1'b0;
        #1 chk("rst_stall_lo", {31'd0, stall_o}, 32'd0);
        start_i = 1'b1;
        tick();

        // Single fetch.
        if_req_i    = 1'b1;
        if_addr_i   = 32'h0000_0010;
        mem_rdata_i = 32'h2001_0004;
        #1 chk("f_stall_req", {31'd0, stall_o}, 32'd1);
        tick();
        for (int i = 1; i <= L; i++) begin
            chk("f_en", {31'd0, mem_en_o}, 32'd1);
            chk("f_addr", mem_addr_o, 32'h0000_0010);
            chk("f_we", {31'd0, mem_we_o}, 32'd0);
            chk("f_no_ack", {31'd0, if_ack_o}, 32'd0);
            chk("f_stall", {31'd0, stall_o}, 32'd1);
            tick();
        end
        chk("f_ack", {31'd0, if_ack_o}, 32'd1);
        chk("f_data", if_data_o, 32'h2001_0004);
        chk("f_en_off", {31'd0, mem_en_o}, 32'd0);
        chk("f_stall_ack", {31'd0, stall_o}, 32'd0);
        if_req_i = 1'b0;
        tick();
        chk("f_ack_once", {31'd0, if_ack_o}, 32'd0);
        chk("f_data_hold", if_data_o, 32'h2001_0004);

        // Write; inputs changed mid-access must not leak through.
        dm_req_i    = 1'b1;
        dm_we_i     = 1'b1;
        dm_addr_i   = 32'h0000_0040;
        dm_wdata_i  = 32'hDEAD_BEEF;
        mem_rdata_i = 32'h1111_1111;
        tick();
        dm_addr_i  = 32'h0000_0999;
        dm_wdata_i = 32'h0;
        dm_we_i    = 1'b0;
        for (int i = 1; i <= L; i++) begin
            chk("w_en", {31'd0, mem_en_o}, 32'd1);
            chk("w_we", {31'd0, mem_we_o}, 32'd1);
            chk("w_addr", mem_addr_o, 32'h0000_0040);
            chk("w_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            chk("w_no_ack", {31'd0, dm_ack_o}, 32'd0);
            tick();
        end
        chk("w_ack", {31'd0, dm_ack_o}, 32'd1);
        chk("w_we_off", {31'd0, mem_we_o}, 32'd0);
        chk("w_en_off", {31'd0, mem_en_o}, 32'd0);
        chk("w_rdata_keep", dm_rdata_o, 32'd0);
        dm_req_i = 1'b0;
        tick();

        // Collision: data first, fetch granted at the end of the following IDLE cycle.
        if_req_i    = 1'b1;
        if_addr_i   = 32'h0000_0020;
        dm_req_i    = 1'b1;
        dm_addr_i   = 32'h0000_0100;
        mem_rdata_i = 32'hCAFE_0100;
        tick();
        for (int i = 1; i <= L; i++) begin
            chk("c_dm_addr", mem_addr_o, 32'h0000_0100);
            chk("c_dm_en", {31'd0, mem_en_o}, 32'd1);
            tick();
        end
        chk("c_dm_ack", {31'd0, dm_ack_o}, 32'd1);
        chk("c_if_wait", {31'd0, if_ack_o}, 32'd0);
        chk("c_dm_rdata", dm_rdata_o, 32'hCAFE_0100);
        chk("c_stall", {31'd0, stall_o}, 32'd1);
        dm_req_i    = 1'b0;
        mem_rdata_i = 32'h1234_5678;
        tick();
        chk("c_idle_en", {31'd0, mem_en_o}, 32'd0);
        chk("c_dm_ack_once", {31'd0, dm_ack_o}, 32'd0);
        tick();
        chk("c_if_en", {31'd0, mem_en_o}, 32'd1);
        chk("c_if_addr", mem_addr_o, 32'h0000_0020);
        for (int i = 1; i <= L; i++) tick();
        chk("c_if_ack", {31'd0, if_ack_o}, 32'd1);
        chk("c_if_data", if_data_o, 32'h1234_5678);
        chk("c_dm_quiet", {31'd0, dm_ack_o}, 32'd0);
        chk("c_dm_rdata_hold", dm_rdata_o, 32'hCAFE_0100);
        if_req_i = 1'b0;
        tick();
        chk("c_if_ack_once", {31'd0, if_ack_o}, 32'd0);

        // Held request: no grant in the ACK cycle, re-grant from IDLE, drop while busy ignored.
        dm_req_i    = 1'b1;
        dm_addr_i   = 32'h0000_0200;
        mem_rdata_i = 32'h0000_0200;
        for (int i = 0; i <= L; i++) tick();
        chk("h_ack1", {31'd0, dm_ack_o}, 32'd1);
        tick();
        chk("h_idle_en", {31'd0, mem_en_o}, 32'd0);
        chk("h_idle_ack", {31'd0, dm_ack_o}, 32'd0);
        tick();
        chk("h_regrant", {31'd0, mem_en_o}, 32'd1);
        dm_req_i = 1'b0;
        for (int i = 1; i <= L; i++) tick();
        chk("h_ack2", {31'd0, dm_ack_o}, 32'd1);
        tick();

        // Reset in the middle of an access abandons it without an ack.
        dm_req_i  = 1'b1;
        dm_addr_i = 32'h0000_0300;
        tick();
        tick();
        chk("r_busy", {31'd0, mem_en_o}, 32'd1);
        start_i = 1'b0;
        #1;
        chk("r_en_drop", {31'd0, mem_en_o}, 32'd0);
        chk("r_dm_ack", {31'd0, dm_ack_o}, 32'd0);
        chk("r_addr", mem_addr_o, 32'd0);
        dm_req_i = 1'b0;
        tick();
        start_i = 1'b1;
        for (int i = 0; i < L + 3; i++) begin
            tick();
            chk("r_no_ack", {31'd0, dm_ack_o}, 32'd0);
            chk("r_idle", {31'd0, mem_en_o}, 32'd0);
        end

`ifdef ARB_PERF_CNT_EN
        chk("p_if_rst", if_grant_cnt_o, 32'd0);
        chk("p_dm_rst", dm_grant_cnt_o, 32'd0);
        chk("p_cf_rst", conflict_cnt_o, 32'd0);
        for (int k = 0; k < 10; k++) begin
            if_req_i  = 1'b1;
            if_addr_i = 32'h0000_1000 + 32'(k);
            dm_req_i  = 1'b1;
            dm_we_i   = 1'b0;
            dm_addr_i = 32'h0000_2000 + 32'(k);
            wait_ack(1'b1, "p_dm_ack");
            dm_req_i = 1'b0;
            wait_ack(1'b0, "p_if_ack");
            if_req_i = 1'b0;
            tick();
        end
        chk("p_if_cnt", if_grant_cnt_o, 32'd10);
        chk("p_dm_cnt", dm_grant_cnt_o, 32'd10);
        chk("p_cf_cnt", conflict_cnt_o, 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
